// File: rtl/hamming.sv
// hamming: chunked Hamming-distance engine.
// Two N-bit operands arrive LSB chunk first, M = N/CC bits per clock.
// The module accumulates the popcount of (g_input ^ e_input) into o.
// The output is live: it shows the running total including the chunk
// currently on the inputs, so the final distance appears while the last
// chunk is still driven. After CC chunks the engine holds until rst.
// Optional build macro HAMMING_SATURATE_EN: when defined, a distance that
// does not fit in W bits reports all ones. When undefined (the default
// build), o reports the low W bits of the distance.
module hamming #(
    parameter int N  = 8,
    parameter int CC = N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N/CC-1:0]        g_input,
    input  logic [N/CC-1:0]        e_input,
    output logic [$clog2(N)-1:0]   o
);
    localparam int M  = N / CC;           // chunk width
    localparam int W  = $clog2(N);        // output width
    localparam int AW = $clog2(N + 1);    // accumulator width, holds N
    localparam int CW = $clog2(CC + 1);   // chunk counter width, holds CC

    // Reject configurations where the chunks cannot tile the operand.
    generate
        if (N < 2 || CC < 1 || (N % CC) != 0) begin : g_bad_cfg
            $error("hamming: N must be >= 2 and divisible by CC");
        end
    endgenerate

    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [M-1:0]  w_diff;
    logic [AW-1:0] w_pop;
    logic          w_active;
    logic [AW-1:0] w_total;

    assign w_diff   = g_input ^ e_input;
    assign w_active = (r_cnt < CW'(CC));

    // Popcount of the differing bits in the current chunk.
    always_comb begin
        w_pop = AW'($countones(w_diff));
    end

    // Running total: the current chunk only counts while the operation is open.
    always_comb begin
        w_total = r_acc;
        if (w_active) begin
            w_total = r_acc + w_pop;
        end
    end

    // Reduce the total to W bits; reset forces a zero output.
    always_comb begin
        o = w_total[W-1:0];
`ifdef HAMMING_SATURATE_EN
        if (|(w_total >> W)) begin
            o = '1;
        end
`endif
        if (rst) begin
            o = '0;
        end
    end

    // Accumulate one chunk per edge until CC chunks are in, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_active) begin
            r_acc <= w_total;
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_hamming.sv
// tb_hamming: scoreboard bench for hamming with three chunkings of N=8
// (CC=8, CC=2, CC=1). The stimulus pushes the expected o for every cycle
// it drives; a monitor pops and compares on the falling edge.
module tb_hamming;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       g8 = 1'b0, e8 = 1'b0;
    logic [3:0] g2 = '0, e2 = '0;
    logic [7:0] g1 = '0, e1 = '0;
    logic [2:0] o8, o2, o1;

    always #5 clk = ~clk;

    hamming #(.N(8), .CC(8)) u_dut8 (.clk(clk), .rst(rst), .g_input(g8), .e_input(e8), .o(o8));
    hamming #(.N(8), .CC(2)) u_dut2 (.clk(clk), .rst(rst), .g_input(g2), .e_input(e2), .o(o2));
    hamming #(.N(8), .CC(1)) u_dut1 (.clk(clk), .rst(rst), .g_input(g1), .e_input(e1), .o(o1));

    typedef struct {
        int sel;
        int exp;
        int op;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   op_id  = 0;

    // Reference: distance reduced to the 3-bit output.
    function automatic int reduce(input int d);
`ifdef HAMMING_SATURATE_EN
        return (d > 7) ? 7 : d;
`else
        return d % 8;
`endif
    endfunction

    function automatic int mwidth(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 4 : 8;
    endfunction

    function automatic int ccount(input int sel);
        return 8 / mwidth(sel);
    endfunction

    // Distance over the lowest 'bits' bit positions of the operands.
    function automatic int dist_low(input logic [7:0] g, input logic [7:0] e, input int bits);
        logic [7:0] m;
        m = (bits >= 8) ? 8'hFF : 8'((1 << bits) - 1);
        return $countones((g ^ e) & m);
    endfunction

    task automatic push(input int sel, input int exp, input int cyc);
        exp_t t;
        t.sel = sel;
        t.exp = exp;
        t.op  = op_id;
        t.cyc = cyc;
        sb_q.push_back(t);
    endtask

    // Put chunk k of G/E on the selected instance; the others see zeros.
    task automatic drive(input int sel, input logic [7:0] g, input logic [7:0] e, input int k);
        logic [7:0] gs;
        logic [7:0] es;
        gs = g >> (k * mwidth(sel));
        es = e >> (k * mwidth(sel));
        g8 = 1'b0; e8 = 1'b0; g2 = '0; e2 = '0; g1 = '0; e1 = '0;
        case (sel)
            0:       begin g8 = gs[0];   e8 = es[0];   end
            1:       begin g2 = gs[3:0]; e2 = es[3:0]; end
            default: begin g1 = gs;      e1 = es;      end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One reset edge with random inputs applied; o must read 0 meanwhile.
    task automatic do_reset(input int sel);
        step();
        rst = 1'b1;
        drive(sel, 8'($urandom), 8'($urandom), 0);
        push(sel, 0, -1);
    endtask

    // Full operation; want >= 0 pins the final distance to a known constant.
    task automatic op(input int sel, input logic [7:0] g, input logic [7:0] e,
                      input int extra, input logic [7:0] xg, input logic [7:0] xe,
                      input int want);
        int cc;
        int fin;
        cc = ccount(sel);
        op_id++;
        do_reset(sel);
        fin = (want >= 0) ? want : dist_low(g, e, 8);
        for (int k = 0; k < cc; k++) begin
            step();
            rst = 1'b0;
            drive(sel, g, e, k);
            if (k == cc - 1) push(sel, reduce(fin), k);
            else             push(sel, reduce(dist_low(g, e, (k + 1) * mwidth(sel))), k);
        end
        for (int x = 0; x < extra; x++) begin
            step();
            drive(sel, xg, xe, 0);
            push(sel, reduce(fin), cc + x);
        end
    endtask

    // Operation abandoned after n chunks; the next op's reset discards it.
    task automatic partial(input int sel, input logic [7:0] g, input logic [7:0] e, input int n);
        op_id++;
        do_reset(sel);
        for (int k = 0; k < n; k++) begin
            step();
            rst = 1'b0;
            drive(sel, g, e, k);
            push(sel, reduce(dist_low(g, e, (k + 1) * mwidth(sel))), k);
        end
    endtask

    // Monitor: compare the selected instance's output once per cycle.
    initial begin
        exp_t t;
        int   got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                t = sb_q.pop_front();
                got = (t.sel == 0) ? int'(o8) : (t.sel == 1) ? int'(o2) : int'(o1);
                checks++;
                if (got != t.exp) begin
                    errors++;
                    $display("FAIL o op=%0d cyc=%0d cc=%0d got=%0d expected=%0d",
                             t.op, t.cyc, ccount(t.sel), got, t.exp);
                end
            end
        end
    end

    initial begin
        // A9 ^ 7B: distance 4, then 4 hold cycles with g=1, e=0.
        op(0, 8'hA9, 8'h7B, 4, 8'hFF, 8'h00, 4);
        op(0, 8'h74, 8'h9D, 1, 8'h00, 8'hFF, 5);
        op(0, 8'hAA, 8'hAA, 1, 8'hFF, 8'h00, 0);
        op(0, 8'hFF, 8'h00, 2, 8'h00, 8'hFF, 8);
        // Abort after 4 differing bits; the next run must not carry them.
        partial(0, 8'h0F, 8'h00, 4);
        op(0, 8'h74, 8'h9D, 1, 8'hFF, 8'h00, 5);
        op(1, 8'hA9, 8'h7B, 2, 8'hFF, 8'h00, 4);
        op(1, 8'hFF, 8'h00, 1, 8'h00, 8'hFF, 8);
        op(2, 8'h74, 8'h9D, 2, 8'hFF, 8'h00, 5);
        op(2, 8'hFF, 8'h00, 1, 8'h12, 8'h34, 8);
        // Randomised operations across all chunkings, some aborted early.
        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            if (ccount(sel) > 1 && $urandom_range(0, 4) == 0)
                partial(sel, 8'($urandom), 8'($urandom), int'($urandom_range(1, ccount(sel) - 1)));
            else
                op(sel, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                   8'($urandom), 8'($urandom), -1);
        end
        step();
        step();
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming.md
Name: hamming

Overview:
- Serial/parallel Hamming-distance engine for the garbled-circuit benchmark set.
- Two N-bit operands, G (garbler) and E (evaluator), arrive in CC chunks of M = N/CC bits, one chunk per clock, LSB chunk first.
- Output o is the number of bit positions where G and E differ.
- Leaf datapath block: no handshake, framed only by reset.

Parameters:
- N, default 8: operand width in bits; N >= 2.
- CC, default N: number of clock cycles (chunks) per operation; must divide N exactly. Elaborate-time error if N % CC != 0.
- M (localparam), N/CC: chunk width in bits.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; starts a new operation.
- g_input  input  M  current chunk of G; chunk k carries G[k*M +: M].
- e_input  input  M  current chunk of E; chunk k carries E[k*M +: M].
- o  output  W  Hamming distance, W = log2(N) using the codebase's ceiling log2 (W = 3 for N = 8).

Behaviour:
- State:
  - acc: accumulator, clog2(N+1) bits, so it can hold N.
  - cnt: chunk counter, clog2(CC+1) bits.
- pop: combinational popcount of (g_input ^ e_input), 0..M.
- Reset:
  - At a rising edge with rst = 1: acc <= 0, cnt <= 0.
  - rst has priority over accumulation.
  - While rst = 1, o is forced to 0 combinationally.
- Accumulate:
  - At a rising edge with rst = 0 and cnt < CC: acc <= acc + pop, cnt <= cnt + 1.
- Hold:
  - At a rising edge with rst = 0 and cnt == CC: acc and cnt hold.
  - Extra input cycles are ignored until the next reset.
- Output (combinational):
  - Let total = acc + (cnt < CC ? pop : 0).
  - o = total reduced to W bits; reduction rule is set by the Optional Feature.
- Timing:
  - The first chunk is the one sampled at the first edge after the reset edge.
  - o is correct while the last chunk (k = CC-1) is still driven, before its sampling edge.
  - o stays correct and stable from that edge onward, regardless of inputs, until rst.
  - Effective latency: 0 cycles after the last chunk is presented.
- CC = 1: o equals the popcount of the full-width XOR combinationally; the value is frozen after one edge.
- Reset mid-operation: partial result discarded; acc and cnt restart from 0 at that edge.
- Chunk order does not affect the result; LSB-first is the defined ordering.
- No X propagation from unused state: acc and cnt are fully reset.

Optional Feature:
- Macro HAMMING_SATURATE_EN.
- Defined: if total > 2^W - 1, o = 2^W - 1 (all ones). For N = 8, a distance of 8 reports 7.
- Undefined (default): o = total mod 2^W, i.e. low W bits. For N = 8, a distance of 8 reports 0.
- Otherwise identical in both builds.

Test Plan:
- N=8, CC=8: reset, then G=A9, E=7B, bitwise LSB first over 8 cycles -> o = 4, while bit 7 is applied and after its edge.
- N=8, CC=8: G=74, E=9D -> o = 5. Then G=AA, E=AA -> o = 0. Fresh reset before each operation.
- N=8, CC=8: G=FF, E=00 -> o = 0 by default; o = 7 with HAMMING_SATURATE_EN.
- Mid-operation reset:
  - N=8, CC=8: feed 4 differing bits, assert rst for one edge.
  - Then run G=74, E=9D -> o = 5; no carry-over.
  - o = 0 during rst.
- Hold after completion: after the A9/7B run, drive 4 more cycles of g=1, e=0 -> o stays 4.
- N=8, CC=2 (M=4): chunks g=9/A, e=B/7 (G=A9, E=7B) -> o = 4 after 2 cycles.
- N=8, CC=1: G=74, E=9D applied in one cycle -> o = 5 immediately, still 5 after the edge.
